// File: rtl/pokey_pot_pkg.sv
// POKEY pot scanner shared constants.
// Holds FSM state encoding and default scan parameters.
package pokey_pot_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DUMP = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;

  localparam int unsigned POT_NUM         = 8;
  localparam int unsigned POT_CNT_W       = 8;
  localparam int unsigned POT_MAX_COUNT   = 228;
  localparam int unsigned POT_MIN_COUNT   = 5;
  localparam int unsigned POT_DUMP_CYCLES = 16;

endpackage

// File: rtl/pot_channel.sv
// One pot channel: 2-flop input sync, allpot busy bit, result register.
// Ports: clk, rst, pot_in, restart, scan_en, terminal, cnt -> busy, val, fin.
module pot_channel
  import pokey_pot_pkg::*;
#(
  parameter int unsigned CNT_W     = POT_CNT_W,
  parameter int unsigned MIN_COUNT = POT_MIN_COUNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pot_in,
  input  logic             restart,
  input  logic             scan_en,
  input  logic             terminal,
  input  logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic [CNT_W-1:0] val,
  output logic             fin
);

  logic s1;
  logic pot_s;
  logic latch;

  assign latch = scan_en & busy &
                 ((pot_s & (cnt >= CNT_W'(MIN_COUNT)))
                  | terminal);

  // fin: channel is idle after this edge
  assign fin = ~busy | latch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      pot_s <= 1'b0;
      busy  <= 1'b0;
      val   <= '0;
    end else begin
      s1    <= pot_in;
      pot_s <= s1;
      if (restart) begin
        busy <= 1'b1;
      end else if (latch) begin
        busy <= 1'b0;
      end
      if (latch) begin
        val <= cnt;
      end
    end
  end

endmodule

// File: rtl/pokey_pot_scanner.sv
// Multi-channel POKEY pot scanner: dump/scan FSM with shared counter.
// Ports: clk, rst, potgo, fast_mode, line_tick, pot_in -> pot_dump, allpot, pot_val, pot_rdy, scan_cnt.
module pokey_pot_scanner
  import pokey_pot_pkg::*;
#(
  parameter int unsigned NUM_POTS    = POT_NUM,
  parameter int unsigned CNT_W       = POT_CNT_W,
  parameter int unsigned MAX_COUNT   = POT_MAX_COUNT,
  parameter int unsigned MIN_COUNT   = POT_MIN_COUNT,
  parameter int unsigned DUMP_CYCLES = POT_DUMP_CYCLES
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      potgo,
  input  logic                      fast_mode,
  input  logic                      line_tick,
  input  logic [NUM_POTS-1:0]       pot_in,
  output logic                      pot_dump,
  output logic [NUM_POTS-1:0]       allpot,
  output logic [NUM_POTS*CNT_W-1:0] pot_val,
  output logic                      pot_rdy,
  output logic [CNT_W-1:0]          scan_cnt
);

  localparam int unsigned DW = $clog2(DUMP_CYCLES + 1);

  generate
    if (MAX_COUNT >= (1 << CNT_W)) begin : g_cnt_chk
      $error("MAX_COUNT must be below 2**CNT_W");
    end
  endgenerate

  logic [1:0]          state;
  logic [DW-1:0]       dump_cnt;
  logic                tick;
  logic                scan_en;
  logic                terminal;
  logic                all_done;
  logic [NUM_POTS-1:0] fin;

  assign tick     = fast_mode | line_tick;
  // potgo suppresses any latch on its own edge
  assign scan_en  = (state == ST_SCAN) & tick & ~potgo;
  assign terminal = (scan_cnt == CNT_W'(MAX_COUNT));
  assign all_done = &fin;
  assign pot_dump = (state == ST_DUMP);

  genvar g;
  generate
    for (g = 0; g < NUM_POTS; g++) begin : g_ch
      pot_channel #(
        .CNT_W     (CNT_W),
        .MIN_COUNT (MIN_COUNT)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .pot_in   (pot_in[g]),
        .restart  (potgo),
        .scan_en  (scan_en),
        .terminal (terminal),
        .cnt      (scan_cnt),
        .busy     (allpot[g]),
        .val      (pot_val[g*CNT_W +: CNT_W]),
        .fin      (fin[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      dump_cnt <= '0;
      scan_cnt <= '0;
      pot_rdy  <= 1'b0;
    end else begin
      pot_rdy <= 1'b0;
      if (potgo) begin
        state    <= ST_DUMP;
        dump_cnt <= '0;
        scan_cnt <= '0;
      end else begin
        unique case (state)
          ST_IDLE: ;
          ST_DUMP: begin
            if (dump_cnt == DW'(DUMP_CYCLES - 1)) begin
              state    <= ST_SCAN;
              scan_cnt <= '0;
            end else begin
              dump_cnt <= dump_cnt + 1'b1;
            end
          end
          ST_SCAN: begin
            if (tick) begin
              if (!terminal) begin
                scan_cnt <= scan_cnt + 1'b1;
              end
              if (all_done) begin
                state   <= ST_IDLE;
                pot_rdy <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
